// File: rtl/cpu_fetch_pipe_pkg.sv
// Shared constants for the fetch pipeline: run-state encoding, opcode field and opcodes.
// The optional retire counter is enabled by defining FETCH_RETIRE_COUNT_EN.
package cpu_fetch_pipe_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } run_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD   = 2'd0,
        PC_SEL_INC    = 2'd1,
        PC_SEL_BRANCH = 2'd2
    } pc_sel_e;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_HALT = 5'b11111;

    function automatic logic [4:0] opcode_of(input logic [15:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic is_halt(input logic [15:0] word);
        return opcode_of(word) == OP_HALT;
    endfunction

endpackage

// File: rtl/cpu_fetch_pipe_pc_unit.sv
// Program counter register and next-PC selection (branch > stall/halt hold > increment).
module cpu_pc_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                state,
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                stall,
    input  logic                halt_pending,
    output logic [PC_WIDTH-1:0] pc
);
    import cpu_fetch_pipe_pkg::*;

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;
    pc_sel_e             w_sel;

    always_comb begin
        w_sel = PC_SEL_HOLD;
        if (state == ST_EXEC) begin
            if (branch) begin
                w_sel = PC_SEL_BRANCH;
            end else if (stall || halt_pending) begin
                w_sel = PC_SEL_HOLD;
            end else begin
                w_sel = PC_SEL_INC;
            end
        end
    end

    // Increment wraps naturally at 2^PC_WIDTH.
    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            PC_SEL_INC:    w_pc_next = r_pc + PC_WIDTH'(1);
            PC_SEL_BRANCH: w_pc_next = branch_target;
            default:       w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/cpu_fetch_pipe.sv
// Instruction fetch and IR shift chain (ID->EX->MEM->WB) with branch flush, stall bubbles and HALT drain.
// Define FETCH_RETIRE_COUNT_EN to build the retired-instruction counter.
module cpu_fetch_pipe #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [15:0]         NOP_WORD = 16'h0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                state,
    input  logic [15:0]         i_datain,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         id_ir,
    output logic [15:0]         ex_ir,
    output logic [15:0]         mem_ir,
    output logic [15:0]         wb_ir,
    output logic [15:0]         retired_count
);
    import cpu_fetch_pipe_pkg::*;

    localparam int NUM_STAGES = 4;
    localparam int ID_S  = 0;
    localparam int EX_S  = 1;
    localparam int MEM_S = 2;
    localparam int WB_S  = 3;

    logic [15:0] r_ir      [NUM_STAGES];
    logic [15:0] w_ir_next [NUM_STAGES];
    logic        w_halt_pending;
    logic        w_exec;

    assign w_exec = (state == ST_EXEC);

    // A HALT anywhere before WB freezes fetch; once it reaches WB the controller takes over.
    assign w_halt_pending = is_halt(r_ir[ID_S]) | is_halt(r_ir[EX_S]) | is_halt(r_ir[MEM_S]);

    cpu_pc_unit #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clock         (clock),
        .reset         (reset),
        .state         (state),
        .branch        (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .halt_pending  (w_halt_pending),
        .pc            (pc)
    );

    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            w_ir_next[s] = NOP_WORD;
        end
        if (w_exec) begin
            // MEM and WB always advance while executing; only ID/EX depend on flush/stall.
            w_ir_next[MEM_S] = r_ir[EX_S];
            w_ir_next[WB_S]  = r_ir[MEM_S];
            if (branch_taken) begin
                w_ir_next[ID_S] = NOP_WORD;
                w_ir_next[EX_S] = NOP_WORD;
            end else if (stall) begin
                w_ir_next[ID_S] = r_ir[ID_S];
                w_ir_next[EX_S] = NOP_WORD;
            end else begin
                w_ir_next[ID_S] = w_halt_pending ? NOP_WORD : i_datain;
                w_ir_next[EX_S] = r_ir[ID_S];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_ir_stage
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_ir[gi] <= NOP_WORD;
                end else begin
                    r_ir[gi] <= w_ir_next[gi];
                end
            end
        end
    endgenerate

    assign id_ir  = r_ir[ID_S];
    assign ex_ir  = r_ir[EX_S];
    assign mem_ir = r_ir[MEM_S];
    assign wb_ir  = r_ir[WB_S];

`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] r_retired_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_retired_count <= 16'h0000;
        end else if (w_exec && (opcode_of(w_ir_next[WB_S]) != OP_NOP)) begin
            r_retired_count <= r_retired_count + 16'd1;
        end
    end

    assign retired_count = r_retired_count;
`else
    assign retired_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_fetch_pipe.sv
// Scoreboard bench for cpu_fetch_pipe: directed scenarios followed by randomized exec/stall/branch traffic.
module tb_cpu_fetch_pipe;

    localparam logic [4:0]  T_NOP_OP  = 5'b00000;
    localparam logic [4:0]  T_HALT_OP = 5'b11111;
    localparam logic [15:0] T_NOP     = 16'h0000;
    localparam logic [7:0]  T_RST_PC  = 8'h00;

    logic        clock = 1'b0;
    logic        reset;
    logic        state;
    logic [15:0] i_datain;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  pc;
    logic [15:0] id_ir, ex_ir, mem_ir, wb_ir, retired_count;

    logic [15:0] mem [256];

    cpu_fetch_pipe #(
        .PC_WIDTH (8),
        .RESET_PC (T_RST_PC),
        .NOP_WORD (T_NOP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .state         (state),
        .i_datain      (i_datain),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .id_ir         (id_ir),
        .ex_ir         (ex_ir),
        .mem_ir        (mem_ir),
        .wb_ir         (wb_ir),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;
    assign i_datain = mem[pc];

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir [4];
        logic [15:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Reference model: pipeline contents as a 4-entry list, index 0 = ID ... 3 = WB.
    logic [7:0]  m_pc;
    logic [15:0] m_ir [4];
    logic [15:0] m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] op(input logic [15:0] w);
        return w[15:11];
    endfunction

    function automatic logic [15:0] rand_word_nohalt();
        logic [15:0] w;
        w = 16'($urandom);
        while (op(w) == T_HALT_OP) w = 16'($urandom);
        return w;
    endfunction

    task automatic model_reset();
        m_pc  = T_RST_PC;
        m_ret = 16'h0000;
        for (int s = 0; s < 4; s++) m_ir[s] = T_NOP;
    endtask

    task automatic model_step(input logic st, input logic stl, input logic br, input logic [7:0] tgt);
        logic [15:0] old [4];
        logic        halting;
        for (int s = 0; s < 4; s++) old[s] = m_ir[s];
        if (!st) begin
            for (int s = 0; s < 4; s++) m_ir[s] = T_NOP;
        end else begin
            halting = (op(old[0]) == T_HALT_OP) || (op(old[1]) == T_HALT_OP) || (op(old[2]) == T_HALT_OP);
            m_ir[3] = old[2];
            m_ir[2] = old[1];
            if (br) begin
                m_ir[0] = T_NOP;
                m_ir[1] = T_NOP;
                m_pc    = tgt;
            end else if (stl) begin
                m_ir[1] = T_NOP;
            end else if (halting) begin
                m_ir[0] = T_NOP;
                m_ir[1] = old[0];
            end else begin
                m_ir[0] = mem[m_pc];
                m_ir[1] = old[0];
                m_pc    = 8'((int'(m_pc) + 1) % 256);
            end
`ifdef FETCH_RETIRE_COUNT_EN
            if (op(old[2]) != T_NOP_OP) m_ret = m_ret + 16'd1;
`endif
        end
    endtask

    task automatic step(input logic st, input logic stl, input logic br, input logic [7:0] tgt);
        exp_t e;
        state         = st;
        stall         = stl;
        branch_taken  = br;
        branch_target = tgt;
        model_step(st, stl, br, tgt);
        e.pc  = m_pc;
        e.ret = m_ret;
        for (int s = 0; s < 4; s++) e.ir[s] = m_ir[s];
        sb_q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    // Emulates the run controller: idles for one clock when HALT sits in WB.
    task automatic step_auto(input logic stl, input logic br, input logic [7:0] tgt);
        step((op(m_ir[3]) == T_HALT_OP) ? 1'b0 : 1'b1, stl, br, tgt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                chk("sb_pc",     32'(pc),            32'(e.pc));
                chk("sb_id_ir",  32'(id_ir),         32'(e.ir[0]));
                chk("sb_ex_ir",  32'(ex_ir),         32'(e.ir[1]));
                chk("sb_mem_ir", 32'(mem_ir),        32'(e.ir[2]));
                chk("sb_wb_ir",  32'(wb_ir),         32'(e.ir[3]));
                chk("sb_retired", 32'(retired_count), 32'(e.ret));
                $display("txn %0d st=%0b stl=%0b br=%0b pc=%02h id=%04h ex=%04h mem=%04h wb=%04h ret=%0d",
                         txn, state, stall, branch_taken, pc, id_ir, ex_ir, mem_ir, wb_ir, retired_count);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        for (int a = 0; a < 256; a++) mem[a] = rand_word_nohalt();
        mem[0] = 16'h0800; mem[1] = 16'h0801; mem[2] = 16'h0802; mem[3] = 16'h0803;
        mem[4] = 16'h0804; mem[5] = 16'hF800; mem[7] = 16'h1234; mem[8'h41] = 16'hF801;

        reset = 1'b0; state = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_pc", 32'(pc), 32'(T_RST_PC));
        chk("reset_id", 32'(id_ir), 32'(T_NOP));
        chk("reset_wb", 32'(wb_ir), 32'(T_NOP));
        chk("reset_ret", 32'(retired_count), 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        // Straight-line fetch, then HALT at address 5.
        step_auto(0, 0, 8'h00);
        chk("first_id", 32'(id_ir), 32'h0800);
        repeat (3) step_auto(0, 0, 8'h00);
        chk("lat_wb", 32'(wb_ir), 32'h0800);
        chk("lat_pc", 32'(pc), 32'h4);
        repeat (5) step_auto(0, 0, 8'h00);
        chk("halt_pc", 32'(pc), 32'h6);
        chk("halt_wb", 32'(wb_ir), 32'hF800);
`ifdef FETCH_RETIRE_COUNT_EN
        chk("halt_retired", 32'(retired_count), 32'd6);
`else
        chk("halt_retired", 32'(retired_count), 32'd0);
`endif
        step_auto(0, 0, 8'h00);
        chk("idle_pc", 32'(pc), 32'h6);

        // Resume and stall with 0x1234 in ID.
        repeat (2) step_auto(0, 0, 8'h00);
        chk("pre_stall_id", 32'(id_ir), 32'h1234);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00);
            chk("stall_pc", 32'(pc), 32'h8);
            chk("stall_id", 32'(id_ir), 32'h1234);
            chk("stall_ex", 32'(ex_ir), 32'(T_NOP));
        end
        step_auto(0, 0, 8'h00);
        chk("post_stall_ex", 32'(ex_ir), 32'h1234);

        // Branch wins over a simultaneous stall.
        step(1'b1, 1'b1, 1'b1, 8'h40);
        chk("br_pc", 32'(pc), 32'h40);
        chk("br_id", 32'(id_ir), 32'(T_NOP));
        chk("br_ex", 32'(ex_ir), 32'(T_NOP));
        step_auto(0, 0, 8'h00);
        chk("br_fetch", 32'(id_ir), 32'(mem[8'h40]));
        step_auto(0, 0, 8'h00);
        chk("halt_in_id", 32'(id_ir), 32'hF801);

        // Branch kills the HALT in ID; fetch continues from 0x10.
        step(1'b1, 1'b0, 1'b1, 8'h10);
        chk("kill_id", 32'(id_ir), 32'(T_NOP));
        repeat (8) step_auto(0, 0, 8'h00);
        chk("no_halt_pc", 32'(pc), 32'h18);

        // PC wrap.
        step(1'b1, 1'b0, 1'b1, 8'hFE);
        repeat (2) step_auto(0, 0, 8'h00);
        chk("wrap_pc0", 32'(pc), 32'h00);
        step_auto(0, 0, 8'h00);
        chk("wrap_pc1", 32'(pc), 32'h01);

        // Asynchronous reset mid-stream.
        repeat (2) step_auto(0, 0, 8'h00);
        reset = 1'b0;
        #1;
        chk("areset_pc", 32'(pc), 32'(T_RST_PC));
        chk("areset_id", 32'(id_ir), 32'(T_NOP));
        chk("areset_ex", 32'(ex_ir), 32'(T_NOP));
        chk("areset_mem", 32'(mem_ir), 32'(T_NOP));
        chk("areset_wb", 32'(wb_ir), 32'(T_NOP));
        chk("areset_ret", 32'(retired_count), 32'h0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;

        // Random traffic with occasional HALTs in memory.
        for (int a = 0; a < 256; a++) begin
            mem[a] = ($urandom_range(0, 24) == 0) ? {T_HALT_OP, 11'($urandom)} : rand_word_nohalt();
        end
        for (int n = 0; n < 500; n++) begin
            logic st;
            st = (op(m_ir[3]) == T_HALT_OP) ? 1'b0 : ($urandom_range(0, 19) != 0);
            step(st, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
        end

        state = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
